multichannel_audio_mixer: RTL and testbench
===========================================

MULTICHANNEL_AUDIO_MIXER -- requirements
Module: multichannel_audio_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of mixed channels (2..16).
REQ-002 SHALL have parameter W, default 8: unsigned channel sample width.
REQ-003 SHALL have parameter GW, default 4: per-channel gain width; unity gain = 2^(GW-1).
REQ-004 SHALL have derived localparam DW = W+1: DAC code width; CW = $clog2(NCH).
REQ-005 Port `clk`, input, 1: the single clock; all state is on its rising edge.
REQ-006 Port `rst_n`, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port `sample_stb`, input, 1: one-cycle pulse requesting a new mix frame.
REQ-008 Port `ch_left`, input, NCH*W: packed left samples; channel k at bits [k*W +: W].
REQ-009 Port `ch_right`, input, NCH*W: packed right samples, same packing.
REQ-010 Port `gain_we`, input, 1: gain register write strobe.
REQ-011 Port `gain_addr`, input, CW: gain register index.
REQ-012 Port `gain_data`, input, GW: gain value written.
REQ-013 Port `mute`, input, 1: forces both DAC codes to 0.
REQ-014 Port `frame_done`, output, 1: one-cycle pulse when new DAC codes are loaded.
REQ-015 Port `overrun`, output, 1: sticky flag, set when a strobe is dropped.
REQ-016 Port `audio_left`, output, 1: left sigma-delta bitstream.
REQ-017 Port `audio_right`, output, 1: right sigma-delta bitstream.

Function
REQ-018 SHALL hold NCH gain registers, written on `gain_we` at the next edge; a `gain_addr` >= NCH is ignored.
REQ-019 FSM states SHALL be IDLE, MIX, SCALE; reset state IDLE.
REQ-020 IDLE + `sample_stb`: latch `ch_left`/`ch_right`, copy gains into shadow registers, clear both accumulators, channel counter = 0, go to MIX.
REQ-021 MIX SHALL add sample[k]*gain[k] to each accumulator, one channel per cycle. Each accumulator SHALL be W+GW+CW bits wide. After channel NCH-1 the FSM goes to SCALE.
REQ-022 SCALE SHALL compute acc >> (GW-1), saturate it to 2^DW-1, and load the result into the DAC code register (0 if `mute`). It SHALL pulse `frame_done` and return to IDLE.
REQ-023 Latency: `frame_done` asserts exactly NCH+2 cycles after the `sample_stb` edge accepted in IDLE.
REQ-024 A `sample_stb` outside IDLE SHALL be ignored and SHALL set `overrun`. `overrun` clears only on reset.
REQ-025 A gain write during MIX/SCALE SHALL update the live register only. It takes effect from the next frame.
REQ-026 A gain write and a strobe in the same cycle: the frame SHALL use the pre-write gain.
REQ-027 `mute` SHALL be sampled in SCALE only.
REQ-028 Each channel SHALL use a first-order sigma-delta DAC, DW-bit excess code. The integrator is DW+2 bits. Feedback is the integrator's top two bits replicated and shifted left by DW. The output flop is registered from the integrator MSB.
REQ-029 DAC output ones-density over 2^DW cycles SHALL equal code/2^DW, within ±1.

Reset
REQ-030 On `rst_n` low: FSM=IDLE; accumulators, DAC codes, `frame_done`, `overrun`, `audio_left`, `audio_right` = 0; gains = 2^(GW-1); DAC integrators = 1<<DW.
REQ-031 Reset mid-frame SHALL abandon the frame, with no `frame_done` and DAC codes at 0.

Structure
REQ-032 The FSM state encoding and unity-gain and saturation constants SHALL live in shared package audio_pkg.
REQ-033 The DAC SHALL be a sub-module sigma_delta_dac, parameter DW, instantiated twice.

Verification
REQ-034 Reset, NCH=4, all channels 100, unity gains, one strobe -> `frame_done` at cycle 6; both codes = 400.
REQ-035 All channels 255, gain 15 -> code saturates at 511; `audio_left` ones-count over 512 cycles = 511 ±1.
REQ-036 Gain ch2 = 0, others unity, samples 10/20/30/40 -> code 70; `mute`=1 in SCALE -> code 0.
REQ-037 Second strobe 2 cycles after first -> ignored, `overrun`=1, first frame result unchanged.
REQ-038 Gain write in MIX cycle 1 -> current frame uses old gain, next frame uses new gain.
REQ-039 Code 256 held for 512 cycles -> ones-count 256 ±1; `rst_n` low mid-MIX -> outputs 0, no `frame_done`.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the multichannel audio mixer: FSM encoding and gain/saturation constants.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX   = 2'd1,
        SCALE = 2'd2
    } mix_state_e;

    // Gain value that leaves a sample unscaled after the final shift.
    function automatic int unsigned unity_gain(input int unsigned gw);
        return 32'd1 << (gw - 32'd1);
    endfunction

    // Largest code a dw-bit DAC can take.
    function automatic int unsigned sat_max(input int unsigned dw);
        return (32'd1 << dw) - 32'd1;
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta DAC: DW-bit excess code in, 1-bit density-modulated stream out.
module sigma_delta_dac #(
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] code,
    output logic          dout
);

    localparam int unsigned IW = DW + 2;

    logic [IW-1:0] integ;
    logic [IW-1:0] fb;
    logic [IW-1:0] sigma;

    // Feedback is the integrator's top bit pair placed above the code range.
    always_comb begin
        fb    = {integ[IW-1], integ[IW-1], {DW{1'b0}}};
        sigma = IW'(code) + fb + integ;
    end

    // Integrator and output flop; integrator starts at mid-range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ <= IW'(1) << DW;
            dout  <= 1'b0;
        end else begin
            integ <= sigma;
            dout  <= integ[IW-1];
        end
    end

endmodule

// File: rtl/multichannel_audio_mixer.sv
// Multichannel mixer: per-frame weighted sum of NCH stereo channels driving two sigma-delta DACs.
module multichannel_audio_mixer
    import audio_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned GW  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_stb,
    input  logic [NCH*W-1:0]        ch_left,
    input  logic [NCH*W-1:0]        ch_right,
    input  logic                    gain_we,
    input  logic [$clog2(NCH)-1:0]  gain_addr,
    input  logic [GW-1:0]           gain_data,
    input  logic                    mute,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    audio_left,
    output logic                    audio_right
);

    localparam int unsigned DW    = W + 1;
    localparam int unsigned CW    = $clog2(NCH);
    localparam int unsigned AW    = W + GW + CW;
    localparam int unsigned PW    = W + GW;
    localparam int unsigned UNITY = unity_gain(GW);
    localparam int unsigned SAT   = sat_max(DW);

    mix_state_e     state;
    logic [GW-1:0]  gains  [NCH];
    logic [GW-1:0]  shadow [NCH];
    logic [W-1:0]   smp_l  [NCH];
    logic [W-1:0]   smp_r  [NCH];
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  acc_l, acc_r;
    logic [DW-1:0]  code_l, code_r;

    logic [AW-1:0]  prod_l, prod_r;
    logic [AW-1:0]  scaled_l, scaled_r;
    logic [DW-1:0]  sat_l, sat_r;
    logic           last_ch;

    // Current channel product and saturated, shifted accumulator results.
    always_comb begin
        prod_l   = AW'(PW'(smp_l[cnt]) * PW'(shadow[cnt]));
        prod_r   = AW'(PW'(smp_r[cnt]) * PW'(shadow[cnt]));
        scaled_l = acc_l >> (GW - 1);
        scaled_r = acc_r >> (GW - 1);
        sat_l    = (scaled_l > AW'(SAT)) ? DW'(SAT) : DW'(scaled_l);
        sat_r    = (scaled_r > AW'(SAT)) ? DW'(SAT) : DW'(scaled_r);
        last_ch  = (cnt == CW'(NCH - 1));
    end

    // Live gain registers; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NCH); k++) gains[k] <= GW'(UNITY);
        end else if (gain_we && ({1'b0, gain_addr} < (CW+1)'(NCH))) begin
            gains[gain_addr] <= gain_data;
        end
    end

    // Frame sequencer: latch inputs, accumulate one channel per cycle, then scale into the DAC codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            code_l     <= '0;
            code_r     <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < int'(NCH); k++) begin
                shadow[k] <= GW'(UNITY);
                smp_l[k]  <= '0;
                smp_r[k]  <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (sample_stb && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_stb) begin
                        for (int k = 0; k < int'(NCH); k++) begin
                            smp_l[k]  <= ch_left[k*W +: W];
                            smp_r[k]  <= ch_right[k*W +: W];
                            shadow[k] <= gains[k];
                        end
                        acc_l <= '0;
                        acc_r <= '0;
                        cnt   <= '0;
                        state <= MIX;
                    end
                end
                MIX: begin
                    acc_l <= acc_l + prod_l;
                    acc_r <= acc_r + prod_r;
                    cnt   <= last_ch ? '0 : cnt + CW'(1);
                    if (last_ch) state <= SCALE;
                end
                SCALE: begin
                    code_l     <= mute ? '0 : sat_l;
                    code_r     <= mute ? '0 : sat_r;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sigma_delta_dac #(.DW(DW)) u_dac_left (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (code_l),
        .dout  (audio_left)
    );

    sigma_delta_dac #(.DW(DW)) u_dac_right (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (code_r),
        .dout  (audio_right)
    );

endmodule

// File: tb/tb_multichannel_audio_mixer.sv
// Directed bench for multichannel_audio_mixer: frame latency, mixing, saturation, mute, overrun, gain timing, reset.
module tb_multichannel_audio_mixer;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned GW  = 4;
    localparam int unsigned CW  = $clog2(NCH);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sample_stb;
    logic [NCH*W-1:0]    ch_left;
    logic [NCH*W-1:0]    ch_right;
    logic                gain_we;
    logic [CW-1:0]       gain_addr;
    logic [GW-1:0]       gain_data;
    logic                mute;
    logic                frame_done;
    logic                overrun;
    logic                audio_left;
    logic                audio_right;

    int n_pass = 0;
    int n_total = 0;

    multichannel_audio_mixer #(.NCH(NCH), .W(W), .GW(GW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_stb  (sample_stb),
        .ch_left     (ch_left),
        .ch_right    (ch_right),
        .gain_we     (gain_we),
        .gain_addr   (gain_addr),
        .gain_data   (gain_data),
        .mute        (mute),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .audio_left  (audio_left),
        .audio_right (audio_right)
    );

    always #5 clk = ~clk;

    // Compare got against want with a +/- tolerance (0 for exact).
    task automatic check(input string tag, input int got, input int want, input int tol);
        n_total++;
        if (got >= want - tol && got <= want + tol) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, want, tol);
    endtask

    task automatic set_ch(input int k, input int l, input int r);
        ch_left[k*W +: W]  = W'(l);
        ch_right[k*W +: W] = W'(r);
    endtask

    task automatic set_all(input int l, input int r);
        for (int k = 0; k < int'(NCH); k++) set_ch(k, l, r);
    endtask

    // All tasks below start and end #1 after a rising edge.
    task automatic write_gain(input int addr, input int data);
        gain_we   = 1'b1;
        gain_addr = CW'(addr);
        gain_data = GW'(data);
        @(posedge clk); #1;
        gain_we   = 1'b0;
    endtask

    // Strobe accepted at the next edge; returns in cycle 1 of the frame.
    task automatic start_frame();
        sample_stb = 1'b1;
        @(posedge clk); #1;
        sample_stb = 1'b0;
    endtask

    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (!frame_done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic count_ones(input int n, output int l, output int r);
        l = 0;
        r = 0;
        repeat (2) @(posedge clk);
        repeat (n) begin
            @(posedge clk); #1;
            l += int'(audio_left);
            r += int'(audio_right);
        end
    endtask

    task automatic frame_and_measure(input string tag, input int want_l, input int want_r);
        int cyc, l, r;
        start_frame();
        wait_done(1, cyc);
        check({tag, "_latency"}, cyc, NCH + 2, 0);
        count_ones(512, l, r);
        check({tag, "_left"}, l, want_l, 1);
        check({tag, "_right"}, r, want_r, 1);
    endtask

    initial begin
        int cyc, l, r, fd_seen;

        rst_n = 1'b0; sample_stb = 1'b0; gain_we = 1'b0; gain_addr = '0;
        gain_data = '0; mute = 1'b0; ch_left = '0; ch_right = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_frame_done", int'(frame_done), 0, 0);
        check("rst_overrun", int'(overrun), 0, 0);
        check("rst_audio_left", int'(audio_left), 0, 0);
        check("rst_audio_right", int'(audio_right), 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unity gains, every channel 100 -> 400 on both sides.
        set_all(100, 100);
        frame_and_measure("unity", 400, 400);

        // Full-scale samples with gain 15 saturate; silent right side stays at 0.
        for (int k = 0; k < int'(NCH); k++) write_gain(k, 15);
        set_all(255, 0);
        frame_and_measure("saturate", 511, 0);

        // Channel 2 gain 0, others unity.
        for (int k = 0; k < int'(NCH); k++) write_gain(k, (k == 2) ? 0 : 8);
        set_ch(0, 10, 40); set_ch(1, 20, 30); set_ch(2, 30, 20); set_ch(3, 40, 10);
        frame_and_measure("gain0", 70, 80);

        // Mute held only during MIX must not affect the codes.
        start_frame();
        mute = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        mute = 1'b0;
        wait_done(5, cyc);
        check("mute_mix_latency", cyc, NCH + 2, 0);
        count_ones(512, l, r);
        check("mute_mix_left", l, 70, 1);
        check("mute_mix_right", r, 80, 1);

        // Mute present in SCALE zeroes both codes.
        start_frame();
        repeat (3) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        mute = 1'b1;
        wait_done(5, cyc);
        mute = 1'b0;
        check("mute_scale_latency", cyc, NCH + 2, 0);
        count_ones(512, l, r);
        check("mute_scale_left", l, 0, 1);
        check("mute_scale_right", r, 0, 1);

        // Second strobe two cycles into the frame is dropped and flagged.
        set_all(50, 0);
        start_frame();
        @(posedge clk); #1;
        set_all(200, 200);
        sample_stb = 1'b1;
        @(posedge clk); #1;
        sample_stb = 1'b0;
        check("overrun_set", int'(overrun), 1, 0);
        wait_done(3, cyc);
        check("overrun_latency", cyc, NCH + 2, 0);
        count_ones(512, l, r);
        check("overrun_left", l, 150, 1);
        check("overrun_right", r, 0, 1);

        // Gain write during MIX only affects the following frame.
        set_all(100, 100);
        start_frame();
        write_gain(2, 8);
        wait_done(2, cyc);
        check("midwrite_latency", cyc, NCH + 2, 0);
        count_ones(512, l, r);
        check("midwrite_old_left", l, 300, 1);
        check("midwrite_old_right", r, 300, 1);
        frame_and_measure("midwrite_new", 400, 400);

        // Gain write coinciding with the strobe: this frame keeps the old gain.
        gain_we = 1'b1; gain_addr = CW'(0); gain_data = GW'(0);
        start_frame();
        gain_we = 1'b0;
        wait_done(1, cyc);
        check("samecyc_latency", cyc, NCH + 2, 0);
        count_ones(512, l, r);
        check("samecyc_old_left", l, 400, 1);
        frame_and_measure("samecyc_new", 300, 300);
        check("overrun_sticky", int'(overrun), 1, 0);

        // Mid-scale code 256.
        write_gain(0, 8);
        set_all(64, 64);
        frame_and_measure("mid", 256, 256);

        // Reset in the middle of MIX abandons the frame and restores unity gains.
        write_gain(0, 0);
        set_all(100, 100);
        start_frame();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_audio_left", int'(audio_left), 0, 0);
        check("midrst_audio_right", int'(audio_right), 0, 0);
        check("midrst_frame_done", int'(frame_done), 0, 0);
        check("midrst_overrun", int'(overrun), 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fd_seen = 0; l = 0; r = 0;
        repeat (64) begin
            @(posedge clk); #1;
            fd_seen += int'(frame_done);
            l += int'(audio_left);
            r += int'(audio_right);
        end
        check("midrst_no_done", fd_seen, 0, 0);
        check("midrst_silent_left", l, 0, 0);
        check("midrst_silent_right", r, 0, 0);
        frame_and_measure("post_rst_unity", 400, 400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
